// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: FSM states,
// LHToReg read-select codes and the default datapath width.
package hilo_muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] LH_NONE = 2'b00;
  localparam logic [1:0] LH_LO   = 2'b01;
  localparam logic [1:0] LH_HI   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/hilo_muldiv_if.sv
// Decoder/register-file side bus of the HI/LO unit; the decoder is the master,
// the multiply/divide unit is the slave.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
) ();

  logic             Start;
  logic             IsDiv;
  logic             IsSigned;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       LHToReg;
  logic [WIDTH-1:0] LHOut;
  logic             Busy;
  logic             Done;
  logic             Stall;

  modport master (
    output Start, IsDiv, IsSigned, A, B, LHToReg,
    input  LHOut, Busy, Done, Stall
  );

  modport slave (
    input  Start, IsDiv, IsSigned, A, B, LHToReg,
    output LHOut, Busy, Done, Stall
  );

endinterface

// File: rtl/hilo_muldiv_iter_core.sv
// Unsigned iterative engine: shift-add multiply and restoring divide, one bit
// per cycle; exposes the post-step accumulator so the final step can be written.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_isDiv,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_nextHi,
  output logic [WIDTH-1:0] o_nextLo
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_isDiv;
  logic [CNT_W-1:0]   r_count;

  logic [2*WIDTH-1:0] w_accStep;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shiftR;
  logic [WIDTH+1:0]   w_trial;

  // Multiply keeps {P_hi, multiplier}; divide keeps {R, Q}, Q starting as the dividend.
  always_comb begin
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_shiftR  = r_acc[2*WIDTH-1:WIDTH-1];
    w_trial   = {1'b0, w_shiftR} - {2'b00, r_opnd};
    w_accStep = {w_sum, r_acc[WIDTH-1:1]};
    if (r_isDiv) begin
      if (!w_trial[WIDTH+1]) begin
        w_accStep = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
        w_accStep = {w_shiftR[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_opnd  <= '0;
      r_isDiv <= 1'b0;
      r_count <= '0;
    end else if (i_load) begin
      r_acc   <= i_isDiv ? {{WIDTH{1'b0}}, i_a} : {{WIDTH{1'b0}}, i_b};
      r_opnd  <= i_isDiv ? i_b : i_a;
      r_isDiv <= i_isDiv;
      r_count <= '0;
    end else if (i_step) begin
      r_acc   <= w_accStep;
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_last   = (r_count == CNT_W'(WIDTH - 1));
  assign o_nextHi = w_accStep[2*WIDTH-1:WIDTH];
  assign o_nextLo = w_accStep[WIDTH-1:0];

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: FSM, HI/LO registers and read mux around the
// iterative core. Define MULDIV_SIGNED_EN to honour IsSigned (MULT/DIV).
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  hilo_muldiv_if.slave bus
);

  state_t           r_state;
  state_t           w_nextState;
  logic             w_load;
  logic             w_step;
  logic             w_finish;
  logic             w_last;
  logic [WIDTH-1:0] w_opA;
  logic [WIDTH-1:0] w_opB;
  logic [WIDTH-1:0] w_coreHi;
  logic [WIDTH-1:0] w_coreLo;
  logic [WIDTH-1:0] w_resHi;
  logic [WIDTH-1:0] w_resLo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Start is only looked at in IDLE, so a Start while busy is simply dropped.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.Start) begin
          w_load      = 1'b1;
          w_nextState = bus.IsDiv ? DIV : MUL;
        end
      end
      MUL, DIV: begin
        w_step = 1'b1;
        if (w_last) begin
          w_finish    = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

`ifdef MULDIV_SIGNED_EN
  logic w_negA;
  logic w_negB;
  logic r_negXor;
  logic r_negA;

  assign w_negA = bus.IsSigned & bus.A[WIDTH-1];
  assign w_negB = bus.IsSigned & bus.B[WIDTH-1];
  assign w_opA  = w_negA ? -bus.A : bus.A;
  assign w_opB  = w_negB ? -bus.B : bus.B;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_negXor <= 1'b0;
      r_negA   <= 1'b0;
    end else if (w_load) begin
      r_negXor <= w_negA ^ w_negB;
      r_negA   <= w_negA;
    end
  end

  // Remainder follows the dividend's sign; product and quotient follow the sign XOR.
  always_comb begin
    w_resHi = w_coreHi;
    w_resLo = w_coreLo;
    if (r_state == MUL) begin
      if (r_negXor) begin
        {w_resHi, w_resLo} = -{w_coreHi, w_coreLo};
      end
    end else begin
      if (r_negXor) begin
        w_resLo = -w_coreLo;
      end
      if (r_negA) begin
        w_resHi = -w_coreHi;
      end
    end
  end
`else
  assign w_opA   = bus.A;
  assign w_opB   = bus.B;
  assign w_resHi = w_coreHi;
  assign w_resLo = w_coreLo;
`endif

  muldiv_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_isDiv  (bus.IsDiv),
    .i_a      (w_opA),
    .i_b      (w_opB),
    .o_last   (w_last),
    .o_nextHi (w_coreHi),
    .o_nextLo (w_coreLo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_hi <= w_resHi;
        r_lo <= w_resLo;
      end
    end
  end

  always_comb begin
    bus.LHOut = '0;
    case (bus.LHToReg)
      LH_LO:   bus.LHOut = r_lo;
      LH_HI:   bus.LHOut = r_hi;
      default: bus.LHOut = '0;
    endcase
  end

  assign bus.Busy  = (r_state != IDLE);
  assign bus.Done  = r_done;
  assign bus.Stall = bus.Busy & (bus.Start | (bus.LHToReg != LH_NONE));

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: behavioural HI/LO model compared every
// cycle, directed cases with literal expectations, then randomized traffic.
module tb_hilo_muldiv;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   checkEn = 0;

  hilo_muldiv_if #(.WIDTH(WIDTH)) bus ();

  hilo_muldiv #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: cycles left in flight, pending result, architectural HI/LO.
  int          mBusyLeft = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;
  logic [31:0] pendHi = '0;
  logic [31:0] pendLo = '0;
  logic        mDone = 1'b0;
  logic [31:0] expOut;

  function automatic logic [63:0] refResult(input logic isDiv, input logic isSigned,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] magA, magB, q, r;
    logic [63:0] p;
    logic        negA, negB;
    negA = 1'b0;
    negB = 1'b0;
`ifdef MULDIV_SIGNED_EN
    negA = isSigned & a[31];
    negB = isSigned & b[31];
`endif
    magA = negA ? (32'd0 - a) : a;
    magB = negB ? (32'd0 - b) : b;
    if (!isDiv) begin
      p = {32'd0, magA} * {32'd0, magB};
      if (negA ^ negB) p = 64'd0 - p;
      return p;
    end
    if (magB == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = magA;
    end else begin
      q = magA / magB;
      r = magA % magB;
    end
    if (negA ^ negB) q = 32'd0 - q;
    if (negA) r = 32'd0 - r;
    return {r, q};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusyLeft <= 0;
      mHi       <= '0;
      mLo       <= '0;
      mDone     <= 1'b0;
    end else begin
      mDone <= 1'b0;
      if (mBusyLeft != 0) begin
        mBusyLeft <= mBusyLeft - 1;
        if (mBusyLeft == 1) begin
          mHi   <= pendHi;
          mLo   <= pendLo;
          mDone <= 1'b1;
        end
      end else if (bus.Start) begin
        {pendHi, pendLo} <= refResult(bus.IsDiv, bus.IsSigned, bus.A, bus.B);
        mBusyLeft        <= WIDTH;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle the outputs are compared against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      case (bus.LHToReg)
        2'b01:   expOut = mLo;
        2'b10:   expOut = mHi;
        default: expOut = 32'd0;
      endcase
      checkOutput("cyc_busy", 32'(bus.Busy), 32'(mBusyLeft != 0));
      checkOutput("cyc_done", 32'(bus.Done), 32'(mDone));
      checkOutput("cyc_stall", 32'(bus.Stall),
                  32'((mBusyLeft != 0) & (bus.Start | (bus.LHToReg != 2'b00))));
      checkOutput("cyc_lhout", bus.LHOut, expOut);
    end
  end

  task automatic applyStimulus(input logic start, input logic isDiv, input logic isSigned,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] lh);
    @(posedge clk);
    #2;
    bus.Start    = start;
    bus.IsDiv    = isDiv;
    bus.IsSigned = isSigned;
    bus.A        = a;
    bus.B        = b;
    bus.LHToReg  = lh;
  endtask

  task automatic waitDone(input string name, output int busyCycles);
    int n;
    n = 0;
    busyCycles = 0;
    do begin
      @(negedge clk);
      if (bus.Busy === 1'b1) busyCycles++;
      n++;
    end while (bus.Done !== 1'b1 && n < WIDTH + 8);
    if (bus.Done !== 1'b1) checkOutput({name, "_timeout"}, 32'(bus.Done), 32'd1);
  endtask

  task automatic readHiLo(input string name, input logic [31:0] expHi,
                          input logic [31:0] expLo);
    #1 bus.LHToReg = 2'b10;
    #1 checkOutput({name, "_hi"}, bus.LHOut, expHi);
    bus.LHToReg = 2'b01;
    #1 checkOutput({name, "_lo"}, bus.LHOut, expLo);
    bus.LHToReg = 2'b00;
  endtask

  task automatic runOp(input string name, input logic isDiv, input logic isSigned,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    int busyCycles;
    applyStimulus(1'b1, isDiv, isSigned, a, b, 2'b00);
    applyStimulus(1'b0, isDiv, isSigned, a, b, 2'b00);
    waitDone(name, busyCycles);
    readHiLo(name, expHi, expLo);
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'($urandom_range(1, 15));
      2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int busyCycles;
    int doneSeen;
    bus.Start    = 1'b0;
    bus.IsDiv    = 1'b0;
    bus.IsSigned = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.LHToReg  = 2'b01;
    rst_n        = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkEn = 1;
    checkOutput("reset_busy", 32'(bus.Busy), 32'd0);
    checkOutput("reset_done", 32'(bus.Done), 32'd0);
    checkOutput("reset_lo", bus.LHOut, 32'd0);
    #2 rst_n = 1'b1;

    $display("[TB] MULTU max operands");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
    waitDone("mul_max", busyCycles);
    checkOutput("mul_max_busy_cycles", 32'(busyCycles), 32'd32);
    checkOutput("mul_max_done", 32'(bus.Done), 32'd1);
    readHiLo("mul_max", 32'hFFFF_FFFE, 32'h0000_0001);

    $display("[TB] DIVU 100/7 with LO read pending");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd100, 32'd7, 2'b01);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd100, 32'd7, 2'b01);
    repeat (5) @(negedge clk);
    checkOutput("div_stall", 32'(bus.Stall), 32'd1);
    waitDone("div_100_7", busyCycles);
    checkOutput("div_done_lhout", bus.LHOut, 32'd14);
    readHiLo("div_100_7", 32'd2, 32'd14);

    $display("[TB] DIVU by zero");
    runOp("div_zero", 1'b1, 1'b0, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF);

    $display("[TB] Start while busy, then back-to-back");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd3, 32'd4, 2'b00);
    for (int c = 1; c <= 12; c++) begin
      applyStimulus((c == 5) || (c == 10), 1'b1, 1'b0, 32'd9, 32'd9, 2'b00);
    end
    waitDone("mul_ignore", busyCycles);
    readHiLo("mul_ignore", 32'd0, 32'd12);
    #1;
    bus.Start   = 1'b1;
    bus.IsDiv   = 1'b0;
    bus.A       = 32'd6;
    bus.B       = 32'd7;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd6, 32'd7, 2'b10);
    @(negedge clk);
    checkOutput("b2b_busy", 32'(bus.Busy), 32'd1);
    checkOutput("b2b_stale_hi", bus.LHOut, 32'd0);
    waitDone("b2b", busyCycles);
    readHiLo("b2b", 32'd0, 32'd42);

    $display("[TB] Reset in the middle of DIVU");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd1000, 32'd3, 2'b01);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd1000, 32'd3, 2'b01);
    repeat (14) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(bus.Busy), 32'd0);
    checkOutput("abort_lo", bus.LHOut, 32'd0);
    #1 rst_n = 1'b1;
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.Done === 1'b1) doneSeen++;
    end
    checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
    runOp("after_abort", 1'b1, 1'b0, 32'd1000, 32'd3, 32'd1, 32'd333);

    $display("[TB] Signed variants");
`ifdef MULDIV_SIGNED_EN
    runOp("mult_neg", 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    runOp("div_neg", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
    runOp("mult_neg", 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
    runOp("div_neg", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC);
`endif

    $display("[TB] Randomized traffic");
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
                    randOperand(), randOperand(), 2'($urandom));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
    repeat (40) @(negedge clk);
    checkEn = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
